// File: rtl/fk_sample_scheduler.sv
// Omni-wheel FK sample scheduler: periodic tick, velocity snapshot,
// FK launch/wait with timeout, and valid/ready result publishing.
module fk_sample_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_stats,
  input  logic signed [15:0]  v1_in,
  input  logic signed [15:0]  v2_in,
  input  logic signed [15:0]  v3_in,
  output logic                fk_start,
  output logic signed [15:0]  fk_v1,
  output logic signed [15:0]  fk_v2,
  output logic signed [15:0]  fk_v3,
  input  logic signed [31:0]  fk_vx,
  input  logic signed [31:0]  fk_vy,
  input  logic signed [31:0]  fk_omega,
  input  logic                fk_done,
  output logic signed [31:0]  out_vx,
  output logic signed [31:0]  out_vy,
  output logic signed [31:0]  out_omega,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t state, state_nx;

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] pm1;
  logic [TW-1:0]       timer;
  logic                tick;
  logic                done_hit;
  logic                to_hit;
  logic                xfer;

  // A shrunk period leaves cnt past the new end; >= forces a prompt wrap.
  assign pm1  = (period == '0) ? '0 : period - 1'b1;
  assign tick = enable && (cnt >= pm1);
  assign xfer = out_valid && out_ready;

  assign fk_start = (state == S_LAUNCH);
  assign busy     = (state != S_IDLE);

  // Period counter: free-runs while enabled, wraps on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; done on the last timer cycle beats the timeout.
  always_comb begin
    state_nx = state;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (fk_done) begin
          done_hit = 1'b1;
          state_nx = S_IDLE;
        end else if (timer == TLAST) begin
          to_hit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Wait timer: cleared on launch, counts WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == S_LAUNCH) begin
      timer <= '0;
    end else if (state == S_WAIT) begin
      timer <= timer + 1'b1;
    end
  end

  // Velocity snapshot, held until the next accepted tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fk_v1 <= '0;
      fk_v2 <= '0;
      fk_v3 <= '0;
    end else if (state == S_IDLE && tick) begin
      fk_v1 <= v1_in;
      fk_v2 <= v2_in;
      fk_v3 <= v3_in;
    end
  end

  // Result register and valid flag; newest result always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vx    <= '0;
      out_vy    <= '0;
      out_omega <= '0;
      out_valid <= 1'b0;
    end else if (done_hit) begin
      out_vx    <= fk_vx;
      out_vy    <= fk_vy;
      out_omega <= fk_omega;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics: saturating counters and sticky timeout, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (clr_stats) begin
      overrun_cnt <= '0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && busy && overrun_cnt != CMAX)
        overrun_cnt <= overrun_cnt + 1'b1;
      if (done_hit && out_valid && !out_ready && drop_cnt != CMAX)
        drop_cnt <= drop_cnt + 1'b1;
      if (to_hit)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fk_sample_scheduler.sv
// Directed bench for fk_sample_scheduler with an FK latency model
// and a result scoreboard.
module tb_fk_sample_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [15:0]        period;
  logic               clr_stats;
  logic signed [15:0] v1_in, v2_in, v3_in;
  logic               fk_start;
  logic signed [15:0] fk_v1, fk_v2, fk_v3;
  logic signed [31:0] fk_vx, fk_vy, fk_omega;
  logic               fk_done;
  logic signed [31:0] out_vx, out_vy, out_omega;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic [7:0]         drop_cnt;
  logic               timeout_err;

  fk_sample_scheduler #(
    .PERIOD_W(16),
    .TIMEOUT (64),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period     (period),
    .clr_stats  (clr_stats),
    .v1_in      (v1_in),
    .v2_in      (v2_in),
    .v3_in      (v3_in),
    .fk_start   (fk_start),
    .fk_v1      (fk_v1),
    .fk_v2      (fk_v2),
    .fk_v3      (fk_v3),
    .fk_vx      (fk_vx),
    .fk_vy      (fk_vy),
    .fk_omega   (fk_omega),
    .fk_done    (fk_done),
    .out_vx     (out_vx),
    .out_vy     (out_vy),
    .out_omega  (out_omega),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun_cnt(overrun_cnt),
    .drop_cnt   (drop_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] vx;
    logic signed [31:0] vy;
    logic signed [31:0] om;
  } res_t;

  res_t q[$];
  int checks = 0;
  int errors = 0;
  int lat = 5;
  int pend = 0;
  int run = 0;
  bit stray = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fk_start && n < 400);
    chk("start_seen", 64'(fk_start), 64'd1);
  endtask

  // FK model: done lat cycles after start; expected result queued.
  always @(negedge clk) begin
    res_t r;
    fk_done  = 1'b0;
    fk_vx    = 32'h0BAD_0001;
    fk_vy    = 32'h0BAD_0002;
    fk_omega = 32'h0BAD_0003;
    if (rst) begin
      pend = 0;
    end else begin
      if (stray) begin
        fk_done = 1'b1;
        stray = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          r.vx = {16'(run), fk_v1};
          r.vy = {fk_v2, 16'(run)};
          r.om = 32'($signed(fk_v1)) + 32'($signed(fk_v2))
               + 32'($signed(fk_v3)) + run;
          fk_vx    = r.vx;
          fk_vy    = r.vy;
          fk_omega = r.om;
          fk_done  = 1'b1;
          if (out_valid && !out_ready && q.size() > 0)
            void'(q.pop_back());
          q.push_back(r);
        end
      end
      if (fk_start) begin
        run++;
        if (lat > 0) pend = lat;
      end
    end
  end

  // Output monitor: every transfer must match the scoreboard head.
  always @(negedge clk) begin
    res_t r;
    if (!rst && out_valid && out_ready) begin
      chk("result_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("out_vx", 64'(out_vx), 64'(r.vx));
        chk("out_vy", 64'(out_vy), 64'(r.vy));
        chk("out_omega", 64'(out_omega), 64'(r.om));
      end
    end
  end

  initial begin
    int n;
    int k;
    logic [7:0] ov0;
    rst = 1'b1; enable = 1'b0; period = 16'd10; clr_stats = 1'b0;
    v1_in = '0; v2_in = '0; v3_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fk_start", 64'(fk_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_fk_v1", 64'(fk_v1), 64'd0);
    chk("rst_out_vx", 64'(out_vx), 64'd0);

    // Nominal run: period 10, latency 5.
    rst = 1'b0; enable = 1'b1;
    v1_in = 16'sd100; v2_in = 16'sd200; v3_in = 16'sd300;
    wait_start(n);
    chk("t1_first_start", 64'(n), 64'd10);
    v1_in = 16'sd7; v2_in = 16'sd8; v3_in = 16'sd9;
    repeat (3) @(negedge clk);
    chk("t1_hold_v1", 64'(fk_v1), 64'd100);
    chk("t1_hold_v2", 64'(fk_v2), 64'd200);
    chk("t1_hold_v3", 64'(fk_v3), 64'd300);
    v1_in = 16'sd100; v2_in = 16'sd200; v3_in = 16'sd300;
    wait_start(n);
    chk("t1_gap_a", 64'(n), 64'd7);
    wait_start(n);
    chk("t1_gap_b", 64'(n), 64'd10);
    chk("t1_overrun", 64'(overrun_cnt), 64'd0);
    chk("t1_drop", 64'(drop_cnt), 64'd0);
    chk("t1_timeout", 64'(timeout_err), 64'd0);

    // Busy longer than period: ticks are lost, not queued.
    period = 16'd4; lat = 9;
    wait_start(n);
    wait_start(n);
    ov0 = overrun_cnt;
    wait_start(n);
    chk("t2_gap", 64'(n), 64'd12);
    chk("t2_overrun_step", 64'(overrun_cnt - ov0), 64'd2);
    chk("t2_drop", 64'(drop_cnt), 64'd0);

    // Stalled consumer: newest result wins, two drops.
    period = 16'd8; lat = 2;
    wait_start(n);
    wait_start(n);
    out_ready = 1'b0;
    wait_start(n);
    wait_start(n);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_valid_held", 64'(out_valid), 64'd1);
    chk("t3_pending", 64'(q.size()), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_valid_clear", 64'(out_valid), 64'd0);
    chk("t3_drained", 64'(q.size()), 64'd0);

    // FK never answers: timeout, then relaunch on next tick.
    period = 16'd100; lat = 0; enable = 1'b1;
    wait_start(n);
    chk("t4_first_start", 64'(n), 64'd100);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout_err && k < 200);
    chk("t4_timeout_delay", 64'(k), 64'd65);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_no_publish", 64'(out_valid), 64'd0);
    lat = 2;
    wait_start(n);
    chk("t4_relaunch", 64'(n), 64'd35);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("t4_clr_timeout", 64'(timeout_err), 64'd0);
    chk("t4_clr_overrun", 64'(overrun_cnt), 64'd0);
    chk("t4_clr_drop", 64'(drop_cnt), 64'd0);

    // Reset during WAIT, then a stray done in IDLE.
    period = 16'd10; lat = 20;
    repeat (8) @(negedge clk);
    wait_start(n);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_start", 64'(fk_start), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_out_vx", 64'(out_vx), 64'd0);
    chk("t5_rst_fk_v1", 64'(fk_v1), 64'd0);
    lat = 5;
    rst = 1'b0;
    stray = 1'b1;
    wait_start(n);
    chk("t5_first_start", 64'(n), 64'd10);
    chk("t5_stray_valid", 64'(out_valid), 64'd0);
    chk("t5_stray_vx", 64'(out_vx), 64'd0);

    // Period 0: tick every cycle, overrun saturates.
    period = 16'd0; lat = 1;
    wait_start(n);
    wait_start(n);
    wait_start(n);
    chk("t6_gap", 64'(n), 64'd3);
    repeat (400) @(negedge clk);
    chk("t6_sat", 64'(overrun_cnt), 64'd255);
    repeat (10) @(negedge clk);
    chk("t6_sat_hold", 64'(overrun_cnt), 64'd255);

    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("end_idle", 64'(busy), 64'd0);
    chk("end_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fk_sample_scheduler.md
Name: fk_sample_scheduler

Overview:
Periodic sequencer for the omni-wheel forward-kinematics datapath. It does four things:
- Generates a programmable sample tick.
- Snapshots the three wheel velocities and holds them stable while the FK block computes.
- Pulses the FK start and waits for done, with a timeout.
- Publishes Vx/Vy/omega on a valid/ready output, tracking overruns, dropped results and timeouts.

Parameters:
PERIOD_W, 16, width of the sample period register.
TIMEOUT, 64, max cycles in WAIT before aborting (must be >= 2).
CNT_W, 8, width of the saturating statistics counters.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
enable  in  1  run the period counter; low stops new ticks.
period  in  PERIOD_W  sample period in cycles (0 treated as 1).
clr_stats  in  1  one-cycle pulse: clears overrun_cnt, drop_cnt, timeout_err.
v1_in, v2_in, v3_in  in  16 signed each  live wheel velocities.
fk_start  out  1  one-cycle start pulse to the FK datapath.
fk_v1, fk_v2, fk_v3  out  16 signed each  held velocity snapshot driving the FK inputs.
fk_vx, fk_vy, fk_omega  in  32 signed each  FK results.
fk_done  in  1  FK result-valid pulse.
out_vx, out_vy, out_omega  out  32 signed each  published results.
out_valid  out  1  published result available.
out_ready  in  1  consumer accepts.
busy  out  1  high in LAUNCH or WAIT.
overrun_cnt  out  CNT_W  ticks lost because the scheduler was busy (saturating).
drop_cnt  out  CNT_W  unaccepted results overwritten (saturating).
timeout_err  out  1  sticky: an FK run timed out.

Behaviour:
- Reset (async, rst high):
  - state=IDLE; period counter, timeout timer, all outputs, snapshot and result registers = 0.
  - Registers hold 0 while rst is high. Reset mid-run aborts immediately with no output.
- Period counter:
  - While enable is high, counts 0..P-1 (P = max(period,1)). tick = enable && cnt==P-1, after which cnt wraps to 0.
  - enable low: cnt forced to 0, no tick.
  - A period change takes effect at the next wrap. If cnt >= new P-1, tick on the next cycle and wrap.
- FSM, states IDLE, LAUNCH, WAIT:
  - IDLE: on tick, capture v1_in..v3_in into fk_v1..fk_v3, go to LAUNCH.
  - LAUNCH: fk_start=1 for exactly this cycle; clear timer; go to WAIT.
  - WAIT: timer increments each cycle.
    - fk_done=1: latch fk_vx/fk_vy/fk_omega into out_*, set out_valid, go to IDLE.
    - Else timer == TIMEOUT-1: set timeout_err, go to IDLE, no publish, out_* unchanged.
    - fk_done on the timeout cycle wins (publish, no error).
  - fk_done outside WAIT is ignored.
- Snapshot: fk_v* change only on capture in IDLE, so they are stable from LAUNCH through the WAIT exit.
- Latency: tick at cycle T → fk_start high in T+1 → for fk_done at cycle D, out_valid high from D+1.
- Overrun: a tick while in LAUNCH or WAIT increments overrun_cnt (saturating at 2^CNT_W-1); the tick is discarded and there is no queueing.
- Output handshake:
  - Transfer occurs when out_valid && out_ready. out_* stay stable while out_valid is high and unaccepted.
  - Transfer with no new result that cycle: out_valid clears next cycle.
  - New result arriving with out_valid high and no transfer that cycle: overwrite (newest wins), drop_cnt+1, out_valid stays 1.
  - New result in the same cycle as a transfer: load the new data, out_valid stays 1, no drop.
- clr_stats: clears the counters and timeout_err next cycle. If an increment or timeout event occurs in the same cycle, clear wins.
- busy = (state != IDLE).
- enable dropped mid-run: the current run completes normally.

Test Plan:
- period=10, enable=1, v=(100,200,300), FK model done 5 cycles after start, out_ready=1 → fk_start every 10 cycles; fk_v held at (100,200,300); out_valid 1-cycle pulses carrying the model outputs; all counters 0.
- period=4, FK latency 9 → fk_start every 12 cycles (tick after each run completes); overrun_cnt +2 per run; no drops.
- period=8, out_ready=0 for 3 results, FK latency 2 → out_* = third result; drop_cnt=2; raise out_ready → single transfer, out_valid clears.
- fk_done never asserted, TIMEOUT=64 → fk_start, then 64 cycles later timeout_err=1, FSM back in IDLE, out_valid stays 0; next tick relaunches; clr_stats clears timeout_err.
- Assert rst during WAIT, then fk_done pulses after release → all outputs 0, the stray done is ignored, first fk_start occurs P cycles after enable with rst low.
- period=0, enable=1 → tick every cycle; fk_start every (latency+2) cycles; overrun_cnt saturates at 255 and holds.
